// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake between a PS/2 transmit client and the host transmitter
//   tx_data  byte to send, sampled when tx_start && tx_ready
//   tx_start one-cycle transmit request
//   tx_ready transmitter idle and accepting a request
//   tx_done  one-cycle pulse, byte acked by the device
//   tx_err   one-cycle pulse, no ack or device timeout
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;
    modport master (output tx_data, tx_start, input tx_ready, tx_done, tx_err);
    modport slave (input tx_data, tx_start, output tx_ready, tx_done, tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device transmitter (inhibit, request-to-send, 11-bit frame, ack check)
//   clk, rst     system clock, asynchronous active-low reset
//   bus          command handshake (ps2_host_tx_if.slave)
//   ps2_clk      raw PS/2 clock pad, ps2_data raw PS/2 data pad
//   ps2_clk_oe   1 pulls ps2_clk low, ps2_data_oe 1 pulls ps2_data low
module ps2_host_tx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int INHIBIT_US = 100,
    parameter int TIMEOUT_US = 15000,
    parameter int FILTER_LEN = 8
) (
    input  logic         clk,
    input  logic         rst,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk,
    input  logic         ps2_data,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int INH_CYC = CLK_FREQ / 1_000_000 * INHIBIT_US;
    localparam int TO_CYC  = CLK_FREQ / 1_000_000 * TIMEOUT_US;
    localparam int CW      = $clog2((INH_CYC > TO_CYC ? INH_CYC : TO_CYC) + 1);
    localparam int FW      = $clog2(FILTER_LEN + 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, START, REQ, SEND, ACK, WAIT_IDLE} state_t;

    state_t          state, next;
    logic [1:0]      sync1, sync2, filt;
    logic [FW-1:0]   fcnt [2];
    logic            clk_prev;
    logic [CW-1:0]   cnt;
    logic [9:0]      shreg;
    logic [3:0]      bitcnt;
    logic            drv, fall, timed, timeout, set_done, set_err;

    // index 0 is the clock pad, index 1 the data pad
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= '1;
            sync2    <= '1;
            filt     <= '1;
            fcnt     <= '{default: '0};
            clk_prev <= 1'b1;
        end else begin
            sync1    <= {ps2_data, ps2_clk};
            sync2    <= sync1;
            clk_prev <= filt[0];
            for (int i = 0; i < 2; i++) begin
                fcnt[i] <= (sync2[i] == filt[i] || fcnt[i] == FW'(FILTER_LEN - 1)) ? '0 : fcnt[i] + 1'b1;
                if (sync2[i] != filt[i] && fcnt[i] == FW'(FILTER_LEN - 1))
                    filt[i] <= sync2[i];
            end
        end
    end

    assign fall    = clk_prev & ~filt[0];
    assign timed   = state inside {REQ, SEND, ACK, WAIT_IDLE};
    assign timeout = timed && cnt == CW'(TO_CYC - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            bus.tx_done <= 1'b0;
            bus.tx_err  <= 1'b0;
        end else begin
            state       <= next;
            bus.tx_done <= set_done;
            bus.tx_err  <= set_err;
        end
    end

    always_comb begin
        next     = state;
        set_done = 1'b0;
        set_err  = 1'b0;
        case (state)
            IDLE:      next = bus.tx_start ? INHIBIT : IDLE;
            INHIBIT:   next = cnt == CW'(INH_CYC - 1) ? START : INHIBIT;
            START:     next = REQ;
            REQ:       next = fall ? SEND : REQ;
            SEND:      next = (fall && bitcnt == 4'd9) ? ACK : SEND;
            ACK: begin
                next    = fall ? (filt[1] ? IDLE : WAIT_IDLE) : ACK;
                set_err = fall & filt[1];
            end
            WAIT_IDLE: begin
                set_done = filt[0] & filt[1];
                next     = set_done ? IDLE : WAIT_IDLE;
            end
            default:   next = IDLE;
        endcase
        // a stalled device overrides whatever the clock edge would have done
        if (timeout) begin
            next     = IDLE;
            set_done = 1'b0;
            set_err  = 1'b1;
        end
    end

    // one counter times the inhibit window and then the per-edge device timeout
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            shreg  <= '1;
            bitcnt <= '0;
            drv    <= 1'b0;
        end else begin
            cnt <= (state == IDLE || state == START || (timed && fall)) ? '0 : cnt + 1'b1;
            if (state == IDLE && bus.tx_start)
                shreg <= {1'b1, ~^bus.tx_data, bus.tx_data};
            // bit 9 of shreg is the stop bit, so the tenth edge releases data naturally
            if (state == REQ) begin
                bitcnt <= '0;
                drv    <= 1'b1;
            end else if (state == SEND && fall) begin
                drv    <= ~shreg[bitcnt];
                bitcnt <= bitcnt + 1'b1;
            end
        end
    end

    assign bus.tx_ready = state == IDLE;
    assign ps2_clk_oe   = state == INHIBIT || state == START;
    assign ps2_data_oe  = state == START || state == REQ || ((state == SEND || state == ACK) && drv);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized self-checking bench with a behavioural PS/2 keyboard model
`timescale 1ns/1ps
module tb_ps2_host_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #500 clk = ~clk;

    ps2_host_tx_if bus ();
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic pad_clk, pad_data;
    assign pad_clk  = !(ps2_clk_oe || dev_clk_low);
    assign pad_data = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .CLK_FREQ(1_000_000), .INHIBIT_US(100), .TIMEOUT_US(2000), .FILTER_LEN(2)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus.slave),
        .ps2_clk(pad_clk), .ps2_data(pad_data),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    int n_checks = 0, n_fail = 0;
    int n_done = 0, n_err = 0, n_both = 0;

    always @(negedge clk) begin
        if (bus.tx_done) n_done++;
        if (bus.tx_err) n_err++;
        if (bus.tx_done && bus.tx_err) n_both++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // expected wire frame: start 0, data LSB-first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] d);
        logic par;
        par = ($countones(d) % 2) == 0;
        return {1'b1, par, d, 1'b0};
    endfunction

    task automatic start_tx(input logic [7:0] d);
        int n;
        bus.tx_data  = d;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        n_checks++;
        if (ps2_clk_oe !== 1'b1) begin
            $display("FAIL start_latency clk_oe=%b required 1", ps2_clk_oe);
            n_fail++;
        end
        n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 1000) begin
            n++;
            @(negedge clk);
        end
        n_checks++;
        if (n !== 100 || ps2_data_oe !== 1'b1) begin
            $display("FAIL inhibit_len cycles=%0d data_oe=%b required 100 and 1", n, ps2_data_oe);
            n_fail++;
        end
    endtask

    // keyboard: waits for request, clocks 12 pulses at 20 cycles, samples data on rises
    task automatic dev_frame(input bit ack, input int abort_k, output logic [10:0] bits);
        int w;
        bits = '0;
        w = 0;
        while (!(pad_clk && !pad_data) && w < 1000) begin
            @(negedge clk);
            w++;
        end
        n_checks++;
        if (w >= 1000) begin
            $display("FAIL request_wait no request-to-send seen within 1000 cycles");
            n_fail++;
            return;
        end
        cyc(20);
        for (int k = 0; k < 12; k++) begin
            dev_clk_low = 1'b1;
            cyc(10);
            if (k == abort_k) return;
            dev_clk_low = 1'b0;
            if (k < 11) bits[k] = pad_data;
            cyc(3);
            if (k == 10) dev_data_low = ack;
            cyc(7);
        end
        cyc(2);
        dev_data_low = 1'b0;
    endtask

    task automatic wait_result();
        int w = 0;
        while (n_done == 0 && n_err == 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        cyc(3);
    endtask

    task automatic check_idle(input string tag);
        n_checks++;
        if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0 || bus.tx_ready !== 1'b1) begin
            $display("FAIL %s_idle clk_oe=%b data_oe=%b ready=%b required 0 0 1",
                     tag, ps2_clk_oe, ps2_data_oe, bus.tx_ready);
            n_fail++;
        end
    endtask

    task automatic test_reset();
        cyc(3);
        n_checks++;
        if (bus.tx_ready !== 1'b1 || bus.tx_done !== 1'b0 || bus.tx_err !== 1'b0) begin
            $display("FAIL reset_flags ready=%b done=%b err=%b required 1 0 0",
                     bus.tx_ready, bus.tx_done, bus.tx_err);
            n_fail++;
        end
        check_idle("reset");
        rst = 1'b1;
        cyc(10);
        check_idle("after_reset");
    endtask

    task automatic test_frame(input logic [7:0] d, input string tag);
        logic [10:0] bits;
        n_done = 0;
        n_err = 0;
        start_tx(d);
        dev_frame(1'b1, -1, bits);
        wait_result();
        n_checks++;
        if (bits !== frame_of(d)) begin
            $display("FAIL %s_frame captured=%h required %h", tag, bits, frame_of(d));
            n_fail++;
        end
        n_checks++;
        if (n_done !== 1 || n_err !== 0) begin
            $display("FAIL %s_result done_pulses=%0d err_pulses=%0d required 1 0", tag, n_done, n_err);
            n_fail++;
        end
        check_idle(tag);
    endtask

    task automatic test_no_ack();
        logic [10:0] bits;
        n_done = 0;
        n_err = 0;
        start_tx(8'h12);
        dev_frame(1'b0, -1, bits);
        cyc(20);
        n_checks++;
        if (n_err !== 1 || n_done !== 0) begin
            $display("FAIL no_ack err_pulses=%0d done_pulses=%0d required 1 0", n_err, n_done);
            n_fail++;
        end
        check_idle("no_ack");
    endtask

    task automatic test_timeout();
        int n;
        n_done = 0;
        n_err = 0;
        start_tx(8'hF4);
        n = 0;
        while (!(!ps2_clk_oe && ps2_data_oe) && n < 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!bus.tx_err && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (n !== 2000) begin
            $display("FAIL timeout_delay cycles=%0d required 2000", n);
            n_fail++;
        end
        check_idle("timeout");
        cyc(5);
        n_checks++;
        if (n_err !== 1 || n_done !== 0) begin
            $display("FAIL timeout_pulses err=%0d done=%0d required 1 0", n_err, n_done);
            n_fail++;
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] bits;
        start_tx(8'hA5);
        dev_frame(1'b1, 5, bits);
        n_checks++;
        if (ps2_data_oe !== 1'b1) begin
            $display("FAIL mid_bit4 data_oe=%b required 1", ps2_data_oe);
            n_fail++;
        end
        #100 rst = 1'b0;
        #1;
        check_idle("mid_reset");
        dev_clk_low = 1'b0;
        cyc(5);
        rst = 1'b1;
        cyc(20);
        test_frame(8'h55, "after_mid_reset");
    endtask

    task automatic test_back_to_back();
        logic [10:0] bits;
        int busy;
        n_done = 0;
        n_err = 0;
        start_tx(8'hED);
        n_checks++;
        if (bus.tx_ready !== 1'b0) begin
            $display("FAIL busy_ready ready=%b required 0", bus.tx_ready);
            n_fail++;
        end
        bus.tx_data  = 8'hAA;
        bus.tx_start = 1'b1;
        @(negedge clk);
        bus.tx_start = 1'b0;
        dev_frame(1'b1, -1, bits);
        wait_result();
        n_checks++;
        if (bits !== frame_of(8'hED)) begin
            $display("FAIL b2b_frame captured=%h required %h", bits, frame_of(8'hED));
            n_fail++;
        end
        busy = 0;
        repeat (200) begin
            @(negedge clk);
            if (ps2_clk_oe) busy++;
        end
        n_checks++;
        if (busy !== 0 || n_done !== 1) begin
            $display("FAIL b2b_dropped extra_clk_oe=%0d done_pulses=%0d required 0 1", busy, n_done);
            n_fail++;
        end
    endtask

    initial begin
        bus.tx_start = 1'b0;
        bus.tx_data  = 8'h00;
        test_reset();
        test_frame(8'hED, "led_cmd");
        test_frame(8'hFF, "reset_cmd");
        test_no_ack();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        for (int i = 0; i < 4; i++) test_frame(8'($urandom_range(0, 255)), "random");
        n_checks++;
        if (n_both !== 0) begin
            $display("FAIL exclusive done_and_err_cycles=%0d required 0", n_both);
            n_fail++;
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
